// File: rtl/cm_sched.sv
// cm_sched: central-module scheduler for the Clos CM switch of the SDM router.
// Round-robin arbitration per output, with grants held until the request is withdrawn.
`default_nettype none

module cm_sched_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] cfg
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  // First requester at or after the pointer, scanning upward with wrap.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = PW'((int'(ptr) + i) % WIDTH);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign ptr_nxt = (pick == PW'(WIDTH - 1)) ? '0 : pick + PW'(1);

  // cfg==0 is the idle state; releasing never re-grants on the same edge,
  // which leaves one dead cycle between owners.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
      ptr <= '0;
    end else if (cfg == '0) begin
      if (found) begin
        cfg <= WIDTH'(1) << pick;
        ptr <= ptr_nxt;
      end
    end else if ((cfg & req) == '0) begin
      cfg <= '0;
    end
  end

endmodule

module cm_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sdec,
  input  logic [3:0] ndec,
  input  logic [3:0] ldec,
  input  logic [1:0] wdec,
  input  logic [1:0] edec,
  output logic [3:0] sra,
  output logic [3:0] nra,
  output logic [3:0] lra,
  output logic [1:0] wra,
  output logic [1:0] era,
  output logic [1:0] scfg,
  output logic [1:0] ncfg,
  output logic [3:0] wcfg,
  output logic [3:0] ecfg,
  output logic [3:0] lcfg,
  output logic [4:0] cms
);

  // Each request bit lands on the cfg bit of the output it names.
  cm_sched_arb #(.WIDTH(2)) u_arb_s (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({ldec[0], ndec[0]}),
    .cfg   (scfg)
  );

  cm_sched_arb #(.WIDTH(2)) u_arb_n (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({ldec[2], sdec[1]}),
    .cfg   (ncfg)
  );

  cm_sched_arb #(.WIDTH(4)) u_arb_w (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({ldec[1], edec[0], ndec[1], sdec[0]}),
    .cfg   (wcfg)
  );

  cm_sched_arb #(.WIDTH(4)) u_arb_e (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({ldec[3], ndec[2], wdec[0], sdec[2]}),
    .cfg   (ecfg)
  );

  cm_sched_arb #(.WIDTH(4)) u_arb_l (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({edec[1], ndec[3], wdec[1], sdec[3]}),
    .cfg   (lcfg)
  );

  // Acks are the transpose of the cfg matrix, straight from the registers.
  assign sra = {lcfg[0], ecfg[0], ncfg[0], wcfg[0]};
  assign nra = {lcfg[2], ecfg[2], wcfg[1], scfg[0]};
  assign lra = {ecfg[3], ncfg[1], wcfg[3], scfg[1]};
  assign wra = {lcfg[1], ecfg[1]};
  assign era = {lcfg[3], wcfg[2]};

  assign cms = {|lcfg, |ecfg, |ncfg, |wcfg, |scfg};

endmodule

`default_nettype wire

// File: tb/tb_cm_sched.sv
// tb_cm_sched: scoreboard bench for cm_sched against a table-driven reference model.
`default_nettype none

module tb_cm_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] sdec, ndec, ldec;
  logic [1:0] wdec, edec;
  logic [3:0] sra, nra, lra;
  logic [1:0] wra, era;
  logic [1:0] scfg, ncfg;
  logic [3:0] wcfg, ecfg, lcfg;
  logic [4:0] cms;

  cm_sched dut (
    .clk(clk), .rst_n(rst_n),
    .sdec(sdec), .ndec(ndec), .ldec(ldec), .wdec(wdec), .edec(edec),
    .sra(sra), .nra(nra), .lra(lra), .wra(wra), .era(era),
    .scfg(scfg), .ncfg(ncfg), .wcfg(wcfg), .ecfg(ecfg), .lcfg(lcfg),
    .cms(cms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] dut_cfg, dut_ack;
  assign dut_cfg = {scfg, ncfg, wcfg, ecfg, lcfg};
  assign dut_ack = {sra, nra, lra, wra, era};

  typedef struct packed {
    logic [15:0] cfg;
    logic [15:0] ack;
    logic [4:0]  cms;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  // Port indices S=0, W=1, N=2, E=3, L=4.
  // srcs[out][cfg bit] = source input; tgt[in][req bit] = target output.
  int nsrc [5]    = '{2, 4, 2, 4, 4};
  int srcs [5][4] = '{'{2, 4, -1, -1}, '{0, 2, 3, 4}, '{0, 4, -1, -1}, '{0, 1, 2, 4}, '{0, 1, 2, 3}};
  int tgt  [5][4] = '{'{1, 2, 3, 4}, '{3, 4, -1, -1}, '{0, 1, 3, 4}, '{1, 4, -1, -1}, '{0, 1, 2, 3}};
  int owner[5];
  int ptr  [5];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [3:0] req_of(input int in);
    case (in)
      0:       return sdec;
      1:       return {2'b00, wdec};
      2:       return ndec;
      3:       return {2'b00, edec};
      default: return ldec;
    endcase
  endfunction

  function automatic bit requesting(input int k, input int j);
    int src;
    logic [3:0] r;
    src = srcs[k][j];
    r = req_of(src);
    for (int b = 0; b < 4; b++)
      if (tgt[src][b] == k) return r[2'(b)];
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 5; k++) begin
      owner[k] = -1;
      ptr[k]   = 0;
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 5; k++) begin
      if (owner[k] >= 0) begin
        if (!requesting(k, owner[k])) owner[k] = -1;
      end else begin
        bit done;
        done = 1'b0;
        for (int i = 0; i < nsrc[k]; i++) begin
          int j;
          j = (ptr[k] + i) % nsrc[k];
          if (!done && requesting(k, j)) begin
            owner[k] = j;
            ptr[k]   = (j + 1) % nsrc[k];
            done     = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    logic [3:0] c[5];
    logic [3:0] a[5];
    for (int k = 0; k < 5; k++)
      c[k] = (owner[k] >= 0) ? (4'(1) << owner[k]) : 4'd0;
    for (int in = 0; in < 5; in++) begin
      a[in] = 4'd0;
      for (int b = 0; b < 4; b++) begin
        int k;
        k = tgt[in][b];
        if (k >= 0 && owner[k] >= 0 && srcs[k][owner[k]] == in) a[in][2'(b)] = 1'b1;
      end
    end
    e.cfg = {c[0][1:0], c[2][1:0], c[1], c[3], c[4]};
    e.ack = {a[0], a[2], a[4], a[1][1:0], a[3][1:0]};
    for (int k = 0; k < 5; k++) e.cms[3'(k)] = (owner[k] >= 0);
    return e;
  endfunction

  function automatic void note_protocol();
    for (int in = 0; in < 5; in++)
      if ($countones(req_of(in)) > 1)
        $display("note: protocol violation, multi-hot request on input %0d", in);
  endfunction

  // Inputs are already set at this negedge; predict the next edge, then move on.
  task automatic step(input string tag);
    note_protocol();
    if (rst_n) model_step();
    exp_q.push_back(model_expect());
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    sdec = '0; ndec = '0; ldec = '0; wdec = '0; edec = '0;
  endtask

  function automatic logic [3:0] rnd_req(input int nb);
    if ($urandom_range(0, 2) == 0) return 4'd0;
    return 4'(1) << $urandom_range(0, nb - 1);
  endfunction

  // Monitor: the DUT presents a fresh output set after every rising edge.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "/cfg"}, dut_cfg, e.cfg);
        check({t, "/ack"}, dut_ack, e.ack);
        check({t, "/cms"}, {11'd0, cms}, {11'd0, e.cms});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] rr_order [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};

  initial begin
    rst_n = 1'b1;
    clear_reqs();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_async_cfg", dut_cfg, 16'd0);
    check("reset_async_cms", {11'd0, cms}, 16'd0);

    // All requests high while in reset: nothing may be granted.
    sdec = 4'hF; ndec = 4'hF; ldec = 4'hF; wdec = 2'h3; edec = 2'h3;
    @(negedge clk);
    repeat (3) step("reset_hold");
    rst_n = 1'b1;
    step("reset_release");
    check("release_bit0", dut_cfg, {2'b01, 2'b01, 4'b0001, 4'b0001, 4'b0001});
    clear_reqs();
    step("release_drop");
    step("idle");

    // Single grant / release: S -> E.
    sdec = 4'b0100;
    step("single_grant");
    check("single_ecfg", {12'd0, ecfg}, 16'h0001);
    check("single_sra", {12'd0, sra}, 16'h0004);
    clear_reqs();
    step("single_release");

    // Round robin on E among W, N, L with single-cycle handovers.
    wdec = 2'b01; ndec = 4'b0100; ldec = 4'b1000;
    for (int p = 0; p < 4; p++) begin
      repeat (3) step("rr_hold");
      check("rr_order", {12'd0, ecfg}, {12'd0, rr_order[p]});
      case (owner[3])
        1:       wdec = 2'b00;
        2:       ndec = 4'b0000;
        3:       ldec = 4'b0000;
        default: ;
      endcase
      step("rr_release");
      check("rr_gap", {12'd0, ecfg}, 16'h0000);
      wdec = 2'b01; ndec = 4'b0100; ldec = 4'b1000;
      step("rr_handover");
    end
    clear_reqs();
    step("rr_end");

    // Contention on S: N holds while L waits.
    ndec = 4'b0001;
    step("cont_n");
    ldec = 4'b0001;
    repeat (3) step("cont_hold");
    check("cont_hold_scfg", {14'd0, scfg}, 16'h0001);
    ndec = 4'b0000;
    step("cont_release");
    check("cont_gap_scfg", {14'd0, scfg}, 16'h0000);
    step("cont_regrant");
    check("cont_l_scfg", {14'd0, scfg}, 16'h0002);
    clear_reqs();
    step("cont_end");

    // Five distinct targets on one edge.
    sdec = 4'b0010; wdec = 2'b01; ndec = 4'b0001; edec = 2'b10; ldec = 4'b0010;
    step("parallel");
    check("parallel_cms", {11'd0, cms}, 16'h001F);
    clear_reqs();
    step("parallel_end");

    // Async reset while E holds W, then full contention on W.
    edec = 2'b01;
    step("ar_grant");
    step("ar_hold");
    check("ar_wcfg", {12'd0, wcfg}, 16'h0004);
    #1 rst_n = 1'b0;
    #1;
    check("ar_clear_cfg", dut_cfg, 16'd0);
    check("ar_clear_ack", dut_ack, 16'd0);
    model_reset();
    #1 rst_n = 1'b1;
    sdec = 4'b0001; ndec = 4'b0010; ldec = 4'b0010;
    step("ar_regrant");
    check("ar_ptr_zero", {12'd0, wcfg}, 16'h0001);
    clear_reqs();
    step("ar_end");

    // Randomised packets: inputs switch target occasionally and hold otherwise.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) sdec = rnd_req(4);
      if ($urandom_range(0, 3) == 0) ndec = rnd_req(4);
      if ($urandom_range(0, 3) == 0) ldec = rnd_req(4);
      if ($urandom_range(0, 3) == 0) wdec = 2'(rnd_req(2));
      if ($urandom_range(0, 3) == 0) edec = 2'(rnd_req(2));
      step("random");
    end
    clear_reqs();
    step("drain");
    @(posedge clk);
    #2;
    check("queue_drain", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
